// File: rtl/fir2x_serializer_if.sv
// Pair-in / sample-out stream bundle for fir2x_serializer.
// master: the environment (upstream FIR plus downstream sink).
// slave:  the serializer itself.
interface fir2x_serializer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] y2k;
  logic [WIDTH-1:0] y2k1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (
    output y2k, y2k1, in_valid, out_ready,
    input  in_ready, out_data, out_valid, overflow
  );

  modport slave (
    input  y2k, y2k1, in_valid, out_ready,
    output in_ready, out_data, out_valid, overflow
  );
endinterface

// File: rtl/fir2x_serializer.sv
// Serializes sample pairs from a 2x-unrolled FIR into one sample per transfer.
// A DEPTH-entry pair FIFO feeds a three-state FSM that emits y2k then y2k1.
// Optional feature: define FIR2X_SER_DROPCNT_EN to add a saturating 16-bit
// count of dropped pairs on port drop_cnt.
module fir2x_serializer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fir2x_serializer_if.slave    bus
`ifdef FIR2X_SER_DROPCNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_e;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  state_e             state_q, state_d;
  logic               overflow_q;

  logic               push, pop, drop;
  logic [2*WIDTH-1:0] head;
  logic               out_valid_c;
  logic [WIDTH-1:0]   out_data_c;

  // Push/drop decisions use the pre-edge count; pop only on the high-half transfer.
  assign push = bus.in_valid && (count_q < DepthC);
  assign drop = bus.in_valid && (count_q == DepthC);
  assign pop  = (state_q == StSendHi) && bus.out_ready;
  assign head = mem_q[rd_ptr_q];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Serializer FSM: next state and Moore outputs.
  always_comb begin
    state_d     = state_q;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StSendLo;
      end
      StSendLo: begin
        out_valid_c = 1'b1;
        out_data_c  = head[WIDTH-1:0];
        if (bus.out_ready) state_d = StSendHi;
      end
      StSendHi: begin
        out_valid_c = 1'b1;
        out_data_c  = head[2*WIDTH-1:WIDTH];
        if (bus.out_ready) state_d = (count_d != '0) ? StSendLo : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: pointers, occupancy, FSM state and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Pair storage; contents are left as-is by reset, only the pointers clear.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= {bus.y2k1, bus.y2k};
  end

`ifdef FIR2X_SER_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating dropped-pair counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign bus.in_ready  = (count_q < DepthC);
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fir2x_serializer.sv
// Scoreboard bench for fir2x_serializer: stimulus pushes expected samples,
// a negedge monitor pops and compares on every output transfer.
module tb_fir2x_serializer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  fir2x_serializer_if #(.WIDTH(WIDTH)) bus ();

`ifdef FIR2X_SER_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  fir2x_serializer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef FIR2X_SER_DROPCNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output sample must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0h expected no output", bus.out_data);
      end else begin
        check("out_sample", bus.out_data, exp_q.pop_front());
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit accept);
    bus.y2k      = a;
    bus.y2k1     = b;
    bus.in_valid = 1'b1;
    if (accept) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'((exp_q.size() == 0) && !bus.out_valid), 32'd1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y2k       = '0;
    bus.y2k1      = '0;
    step();
    step();
    reset = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
`ifdef FIR2X_SER_DROPCNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Single pair: latency and ordering
    bus.out_ready = 1'b1;
    drive_pair(32'd11, 32'd24, 1'b1);
    check("lat_not_yet_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_first_data", bus.out_data, 32'd11);
    step();
    check("second_data", bus.out_data, 32'd24);
    step();
    check("single_idle_valid", 32'(bus.out_valid), 32'd0);
    check("single_idle_data", bus.out_data, 32'd0);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Fill to capacity, then overflow
    bus.out_ready = 1'b0;
    drive_pair(32'd1, 32'd2, 1'b1);
    drive_pair(32'd3, 32'd4, 1'b1);
    drive_pair(32'd5, 32'd6, 1'b1);
    drive_pair(32'd7, 32'd8, 1'b1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_no_overflow_yet", 32'(bus.overflow), 32'd0);
    drive_pair(32'd9, 32'd10, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
`ifdef FIR2X_SER_DROPCNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    bus.out_ready = 1'b1;
    wait_drain("ovf_drain", 40);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_in_ready_after", 32'(bus.in_ready), 32'd1);

    // Stall in the high half
    do_reset();
    drive_pair(32'hFFFF_FFFB, 32'hFFFF_FFF9, 1'b1);
    step();
    check("stall_lo_data", bus.out_data, 32'hFFFF_FFFB);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hi_valid", 32'(bus.out_valid), 32'd1);
      check("stall_hi_data", bus.out_data, 32'hFFFF_FFF9);
      step();
    end
    bus.out_ready = 1'b1;
    wait_drain("stall_drain", 10);

    // Push on the same edge as the high-half pop
    do_reset();
    drive_pair(32'd1000, 32'd2000, 1'b1);
    drive_pair(32'd3000, 32'd4000, 1'b1);
    bus.out_ready = 1'b1;
    step();
    drive_pair(32'd100, 32'd200, 1'b1);
    check("simul_in_ready", 32'(bus.in_ready), 32'd1);
    check("simul_no_drop", 32'(bus.overflow), 32'd0);
    wait_drain("simul_drain", 20);

    // Reset while mid-pair with three pairs stored
    do_reset();
    drive_pair(32'd501, 32'd502, 1'b1);
    drive_pair(32'd503, 32'd504, 1'b1);
    drive_pair(32'd505, 32'd506, 1'b1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("mid_in_send_hi", bus.out_data, 32'd502);
    do_reset();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    bus.out_ready = 1'b1;
    step();
    step();
    check("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
    drive_pair(32'd42, 32'd43, 1'b1);
    wait_drain("mid_rst_drain", 10);
    for (int i = 0; i < 4; i++) step();

    // Sustained stream with pointer wrap
    do_reset();
    bus.out_ready = 1'b1;
    begin
      int start_out;
      start_out = n_out;
      for (int i = 0; i < 64; i++) begin
        drive_pair(32'(i * 7 - 100), ~32'(i * 7 - 100), 1'b1);
        step();
      end
      wait_drain("stream_drain", 20);
      check("stream_count", 32'(n_out - start_out), 32'd128);
      check("stream_overflow", 32'(bus.overflow), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir2x_serializer.md
FIR2X_SERIALIZER -- requirements
Module: fir2x_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the FIFO capacity in sample pairs (power of two, 2..16).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset: synchronous and active-low, so reset=0 at a rising clk edge resets the block.
REQ-005 Port y2k  input  WIDTH  carries the even (earlier) sample of a parallel pair from the 2x-unrolled FIR.
REQ-006 Port y2k1  input  WIDTH  carries the odd (later) sample of the same pair.
REQ-007 Port in_valid  input  1  marks a pair present on y2k/y2k1 this cycle.
REQ-008 Port in_ready  output  1  is high when the FIFO can accept a pair (count < DEPTH).
REQ-009 Port out_data  output  WIDTH  carries the serial sample stream.
REQ-010 Port out_valid  output  1  marks out_data valid.
REQ-011 Port out_ready  input  1  is downstream acceptance; a transfer occurs when out_valid=1 and out_ready=1.
REQ-012 Port overflow  output  1  is a sticky flag set when a pair is dropped.

Function
REQ-013 The block SHALL be a DEPTH-entry pair FIFO (write pointer, read pointer, count 0..DEPTH) followed by a serializer FSM.
REQ-014 Push SHALL occur iff in_valid=1 and count<DEPTH, using the count value before the edge; it stores {y2k1,y2k} at the write pointer, and the write pointer wraps modulo DEPTH.
REQ-015 When in_valid=1 and count==DEPTH, the pair SHALL be dropped and overflow set to 1, even if a pop occurs in the same cycle.
REQ-016 FSM states: IDLE, SEND_LO, SEND_HI.
REQ-017 Transitions:
- IDLE->SEND_LO when count>0.
- SEND_LO->SEND_HI on transfer.
- SEND_HI->SEND_LO on transfer if post-pop count>0.
- SEND_HI->IDLE on transfer if post-pop count==0.
- All states hold when there is no transfer.
REQ-018 out_valid SHALL be 1 exactly in SEND_LO and SEND_HI.
REQ-019 out_data SHALL be the head y2k in SEND_LO, the head y2k1 in SEND_HI, and 0 in IDLE.
REQ-020 Pop (read pointer +1 mod DEPTH, count-1) SHALL occur only on a transfer in SEND_HI.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and SHALL NOT corrupt the head entry.
REQ-022 Latency: a pair pushed at edge N SHALL appear as out_data=y2k with out_valid=1 in the cycle after edge N+1 when the FIFO was empty and the FSM was IDLE.
REQ-023 Sustained throughput SHALL be 1 sample/cycle; the upstream FIR SHALL assert in_valid at most every other cycle on average to avoid overflow.
REQ-024 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 No arithmetic SHALL be performed on samples; bits SHALL pass unchanged.

Reset
REQ-026 On reset=0 at a rising edge, the block SHALL set:
- state=IDLE, pointers=0, count=0.
- out_valid=0, out_data=0, in_ready=1, overflow=0.
REQ-027 Reset mid-operation SHALL discard all stored pairs, including a half-sent pair, with no further outputs until a new push.
REQ-028 Any push or transfer presented in a reset cycle SHALL be ignored.
REQ-029 FIFO storage contents need not be cleared by reset.

Configuration
REQ-030 Macro FIR2X_SER_DROPCNT_EN, when defined, SHALL add port drop_cnt  output  16  counting dropped pairs, saturating at 65535 and cleared to 0 by reset.
REQ-031 Without FIR2X_SER_DROPCNT_EN, port drop_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then push one pair (y2k=11, y2k1=24) with out_ready=1 -> out_data=11 then 24 on consecutive cycles, then out_valid=0 and state IDLE.
REQ-033 Push 4 pairs (1,2),(3,4),(5,6),(7,8) with out_ready=0, then a fifth pair (9,10) -> in_ready=0, overflow=1, drop_cnt=1 (if enabled); with out_ready=1 the output is 1..8 in order and 9 never appears.
REQ-034 Hold out_ready=0 in SEND_HI with head (-5,-7) -> out_data stays -7 and out_valid stays 1 until out_ready=1.
REQ-035 FIFO holds 2 pairs; push (100,200) on the same edge as the SEND_HI transfer -> count unchanged, no drop, and (100,200) emerges after the second pair.
REQ-036 Assert reset=0 while in SEND_HI with 3 pairs stored -> next cycle out_valid=0, in_ready=1, overflow=0; a new pair (42,43) emits 42,43 only.
REQ-037 Push a pair every other cycle for 64 pairs with out_ready=1 -> 128 samples in order, overflow=0, with pointer wrap-around exercised.
